// File: rtl/afifo_wr_arb_if.sv
`default_nettype none
// ============================================================================
// Module  : afifo_wr_arb_if
// Brief   : Requester, RAM write-port and pointer bundle of the FIFO write side.
// Revision: 1.0  initial release
// ============================================================================
interface afifo_wr_arb_if #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 8,
  parameter int NREQ   = 4
);
  logic [NREQ-1:0]        req_valid_i;
  logic [NREQ*DWIDTH-1:0] req_data_i;
  logic [NREQ-1:0]        req_ready_o;
  logic [AWIDTH:0]        rd_pntr_gray_i;
  logic [AWIDTH:0]        wr_pntr_gray_o;
  logic                   mem_wr_en_o;
  logic [AWIDTH-1:0]      mem_wr_addr_o;
  logic [DWIDTH-1:0]      mem_wr_data_o;
  logic                   full_o;
  logic [AWIDTH:0]        used_o;
  logic [NREQ-1:0]        grant_o;

  // Controller side.
  modport slave (
    input  req_valid_i, req_data_i, rd_pntr_gray_i,
    output req_ready_o, wr_pntr_gray_o, mem_wr_en_o, mem_wr_addr_o,
           mem_wr_data_o, full_o, used_o, grant_o
  );

  // Requesters, RAM and synchronizer side.
  modport master (
    output req_valid_i, req_data_i, rd_pntr_gray_i,
    input  req_ready_o, wr_pntr_gray_o, mem_wr_en_o, mem_wr_addr_o,
           mem_wr_data_o, full_o, used_o, grant_o
  );
endinterface
`default_nettype wire

// File: rtl/afifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module  : afifo_wr_arb
// Brief   : Round-robin write arbiter and write-pointer / full / used logic of
//           a dual-clock FIFO.
// Revision: 1.0  initial release
// ============================================================================
module afifo_wr_arb #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 8,
  parameter int NREQ   = 4
) (
  input  wire logic          clk_i,
  input  wire logic          aclr_i,
  afifo_wr_arb_if.slave      bus
);

  localparam int              C_IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [C_IW-1:0] C_LAST_RST = C_IW'(NREQ - 1);

  logic [AWIDTH:0]   r_wbin;
  logic [AWIDTH:0]   r_wgray;
  logic              r_full;
  logic [AWIDTH:0]   r_used;
  logic [NREQ-1:0]   r_grant;
  logic [C_IW-1:0]   r_last;

  logic              w_sel_found;
  logic [C_IW-1:0]   w_sel_idx;
  logic [C_IW-1:0]   w_cand;
  int                w_tmp;
  logic              w_accept;
  logic [NREQ-1:0]   w_ready;
  logic [AWIDTH:0]   w_wbin_next;
  logic [AWIDTH:0]   w_wgray_next;
  logic [AWIDTH:0]   w_rd_bin;
  logic [AWIDTH:0]   w_rd_full_cmp;
  logic              w_full_next;
  logic [AWIDTH:0]   w_used_next;

  // Search starts one past the last winner and wraps around.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_tmp       = 0;
    w_cand      = '0;
    for (int off = 1; off <= NREQ; off++) begin
      w_tmp  = (int'(r_last) + off) % NREQ;
      w_cand = C_IW'(w_tmp);
      if (!w_sel_found && bus.req_valid_i[w_cand]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = w_cand;
      end
    end
  end

  // Full is registered, so a freshly freed slot is usable one cycle later.
  assign w_accept = w_sel_found & ~r_full & ~aclr_i;

  always_comb begin
    w_ready = '0;
    if (w_accept) begin
      w_ready[w_sel_idx] = 1'b1;
    end
  end

  assign w_wbin_next  = r_wbin + {{AWIDTH{1'b0}}, w_accept};
  assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);

  always_comb begin
    w_rd_bin = '0;
    for (int i = 0; i <= AWIDTH; i++) begin
      w_rd_bin[i] = ^(bus.rd_pntr_gray_i >> i);
    end
  end

  // Full when the write pointer is exactly one lap ahead of the read pointer.
  assign w_rd_full_cmp = {~bus.rd_pntr_gray_i[AWIDTH:AWIDTH-1],
                          bus.rd_pntr_gray_i[AWIDTH-2:0]};
  assign w_full_next   = (w_wgray_next == w_rd_full_cmp);
  assign w_used_next   = w_wbin_next - w_rd_bin;

  always_ff @(posedge clk_i or posedge aclr_i) begin
    if (aclr_i) begin
      r_wbin  <= '0;
      r_wgray <= '0;
      r_full  <= 1'b0;
      r_used  <= '0;
      r_grant <= '0;
      r_last  <= C_LAST_RST;
    end else begin
      r_full  <= w_full_next;
      r_used  <= w_used_next;
      r_wgray <= w_wgray_next;
      r_wbin  <= w_wbin_next;
      if (w_accept) begin
        r_last  <= w_sel_idx;
        r_grant <= w_ready;
      end
    end
  end

  assign bus.req_ready_o    = w_ready;
  assign bus.mem_wr_en_o    = w_accept;
  assign bus.mem_wr_addr_o  = r_wbin[AWIDTH-1:0];
  assign bus.mem_wr_data_o  = bus.req_data_i[int'(w_sel_idx)*DWIDTH +: DWIDTH];
  assign bus.wr_pntr_gray_o = r_wgray;
  assign bus.full_o         = r_full;
  assign bus.used_o         = r_used;
  assign bus.grant_o        = r_grant;

endmodule
`default_nettype wire
